// File: rtl/math_divider_pkg.sv
// math_divider_pkg: shared FSM encoding and step/counter sizing for the sequential divider.
package math_divider_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    function automatic int num_steps(input int xw, input int rb);
        return xw / rb;
    endfunction

    function automatic int cnt_width(input int xw, input int rb);
        return $clog2(xw / rb + 1);
    endfunction
endpackage

// File: rtl/math_divider_attempt_row.sv
// math_divider_attempt_row: one shift / trial-subtract / select stage of the restoring divider.
module math_divider_attempt_row #(
    parameter int yWIDTH = 4
) (
    input  logic [yWIDTH:0]   pr_i,
    input  logic              bit_i,
    input  logic [yWIDTH-1:0] d_i,
    output logic [yWIDTH:0]   pr_o,
    output logic              q_o
);
    logic [yWIDTH+1:0] tr;
    // pr_i is always below the divisor, so its top bit is zero and the shift cannot overflow
    assign tr   = {pr_i, bit_i} - {2'b0, d_i};
    assign q_o  = ~tr[yWIDTH+1];
    assign pr_o = q_o ? tr[yWIDTH:0] : {pr_i[yWIDTH-1:0], bit_i};
endmodule

// File: rtl/math_divider_seq.sv
// math_divider_seq: sequential signed/unsigned divider resolving RADIX_BITS quotient bits per cycle.
module math_divider_seq
    import math_divider_pkg::*;
#(
    parameter int xWIDTH     = 8,
    parameter int yWIDTH     = 4,
    parameter int RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sgn,
    input  logic [xWIDTH-1:0] x,
    input  logic [yWIDTH-1:0] y,
    output logic              ready,
    output logic              valid,
    output logic [xWIDTH-1:0] q,
    output logic [yWIDTH-1:0] r,
    output logic              div0,
    output logic              ovf
);
    localparam int N  = num_steps(xWIDTH, RADIX_BITS);
    localparam int CW = cnt_width(xWIDTH, RADIX_BITS);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [xWIDTH-1:0] a_q, q_q, xm, a_d, q_d;
    logic [yWIDTH:0]   pr_q;
    logic [yWIDTH-1:0] d_q, r_q, ym, r_d;
    logic              sx_q, sy_q, z_q, o_q, div0_q, ovf_q, valid_q, accept;
    logic [yWIDTH:0]   pr_c [RADIX_BITS+1];
    logic [RADIX_BITS-1:0] qb;

    assign accept = state_q == IDLE && start;
    assign xm     = (sgn && x[xWIDTH-1]) ? -x : x;
    assign ym     = (sgn && y[yWIDTH-1]) ? -y : y;
    assign pr_c[0] = pr_q;

    for (genvar i = 0; i < RADIX_BITS; i++) begin : g_row
        math_divider_attempt_row #(.yWIDTH(yWIDTH)) u_row (
            .pr_i (pr_c[i]),
            .bit_i(a_q[xWIDTH-1-i]),
            .d_i  (d_q),
            .pr_o (pr_c[i+1]),
            .q_o  (qb[RADIX_BITS-1-i])
        );
    end

    // a_q shifts dividend bits out of the top while quotient bits enter at the bottom
    assign a_d = (a_q << RADIX_BITS) | xWIDTH'(qb);
    assign q_d = z_q ? '1 : ((sx_q ^ sy_q) ? -a_q : a_q);
    assign r_d = z_q ? '0 : (sx_q ? -pr_q[yWIDTH-1:0] : pr_q[yWIDTH-1:0]);

    always_comb begin
        state_d = accept ? CALC :
                  (state_q == CALC && cnt_q == CW'(1)) ? FIX :
                  (state_q == FIX) ? IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            pr_q    <= '0;
            d_q     <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            z_q     <= 1'b0;
            o_q     <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= state_q == FIX;
            if (accept) begin
                sx_q  <= sgn & x[xWIDTH-1];
                sy_q  <= sgn & y[yWIDTH-1];
                a_q   <= xm;
                d_q   <= ym;
                pr_q  <= '0;
                cnt_q <= CW'(N);
                z_q   <= y == '0;
                o_q   <= sgn && x == {1'b1, {(xWIDTH-1){1'b0}}} && y == '1;
            end
            if (state_q == CALC) begin
                a_q   <= a_d;
                pr_q  <= pr_c[RADIX_BITS];
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_q == FIX) begin
                q_q    <= q_d;
                r_q    <= r_d;
                div0_q <= z_q;
                ovf_q  <= o_q;
            end
        end
    end

    assign ready = state_q == IDLE;
    assign valid = valid_q;
    assign q     = q_q;
    assign r     = r_q;
    assign div0  = div0_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_math_divider_seq.sv
// tb_math_divider_seq: random and directed checks of three radix variants against an arithmetic model.
module tb_math_divider_seq;
    logic clk = 1'b0;
    logic rst, start, sgn;
    logic [7:0] x;
    logic [3:0] y;
    logic [2:0] rdy, vld, dz, ov;
    logic [2:0][7:0] qo;
    logic [2:0][3:0] ro;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        math_divider_seq #(.xWIDTH(8), .yWIDTH(4), .RADIX_BITS(1 << g)) dut (
            .clk(clk), .rst(rst), .start(start), .sgn(sgn), .x(x), .y(y),
            .ready(rdy[g]), .valid(vld[g]), .q(qo[g]), .r(ro[g]),
            .div0(dz[g]), .ovf(ov[g])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic s, input logic [7:0] a, input logic [3:0] b,
                                  output logic [7:0] eq, output logic [3:0] er,
                                  output logic ed, output logic eo);
        int xa, yb;
        xa = s ? int'($signed(a)) : int'(a);
        yb = s ? int'($signed(b)) : int'(b);
        ed = 1'b0;
        eo = 1'b0;
        if (b == 4'h0) begin
            eq = 8'hFF; er = 4'h0; ed = 1'b1;
        end else if (s && a == 8'h80 && b == 4'hF) begin
            eq = 8'h80; er = 4'h0; eo = 1'b1;
        end else begin
            eq = 8'(xa / yb); er = 4'(xa % yb);
        end
    endfunction

    task automatic run_op(input logic s, input logic [7:0] a, input logic [3:0] b);
        logic [7:0] eq;
        logic [3:0] er;
        logic ed, eo;
        int lat [3];
        int busy_ok [3];
        model(s, a, b, eq, er, ed, eo);
        sgn = s; x = a; y = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; sgn = 1'($urandom); x = 8'($urandom); y = 4'($urandom);
        for (int k = 0; k < 3; k++) begin lat[k] = 0; busy_ok[k] = 1; end
        for (int c = 1; c <= 10; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (lat[k] == 0) begin
                    if (vld[k]) begin
                        lat[k] = c;
                        check("q", qo[k], eq);
                        check("r", ro[k], er);
                        check("div0", dz[k], ed);
                        check("ovf", ov[k], eo);
                        check("ready_at_valid", rdy[k], 1);
                    end else if (rdy[k]) busy_ok[k] = 0;
                end
            end
            if (c < 10) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            check("latency", lat[k], 8 / (1 << k) + 2);
            check("busy", busy_ok[k], 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sgn = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", rdy, 3'b111);
        check("rst_valid", vld, 0);
        check("rst_q", qo, 0);
        check("rst_r", ro, 0);
        check("rst_flags", {dz, ov}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 8'd200, 4'd7);
        check("dir_u_q", qo[0], 28);
        check("dir_u_r", ro[0], 4);
        run_op(1'b1, 8'h9C, 4'h7);
        check("dir_s1_q", qo[0], 8'hF2);
        check("dir_s1_r", ro[0], 4'hE);
        run_op(1'b1, 8'd100, 4'hA);
        check("dir_s2_q", qo[0], 8'hF0);
        check("dir_s2_r", ro[0], 4'h4);
        run_op(1'b0, 8'd55, 4'h0);
        check("dir_div0", {qo[0], ro[0], dz[0], ov[0]}, {8'hFF, 4'h0, 2'b10});
        run_op(1'b1, 8'h80, 4'hF);
        check("dir_ovf", {qo[0], ro[0], dz[0], ov[0]}, {8'h80, 4'h0, 2'b01});
        run_op(1'b1, 8'h12, 4'h0);
        run_op(1'b0, 8'h80, 4'hF);
        run_op(1'b1, 8'h7F, 4'h8);

        // held start during busy, then back-to-back acceptance in the valid cycle
        sgn = 1'b0; x = 8'd200; y = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        x = 8'd77; y = 4'd5; start = 1'b1;
        for (int c = 3; c < 10; c++) begin
            check("held_valid", vld[0], 0);
            check("held_ready", rdy[0], 0);
            @(negedge clk);
        end
        check("b2b_valid1", vld[0], 1);
        check("b2b_q1", qo[0], 28);
        check("b2b_r1", ro[0], 4);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 11; c < 20; c++) begin
            check("b2b_gap", vld[0], 0);
            @(negedge clk);
        end
        check("b2b_valid2", vld[0], 1);
        check("b2b_q2", qo[0], 15);
        check("b2b_r2", ro[0], 2);
        repeat (12) @(negedge clk);

        // reset in the middle of an operation
        sgn = 1'b0; x = 8'd200; y = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", rdy, 3'b111);
        check("abort_q", qo, 0);
        check("abort_r", ro, 0);
        for (int c = 6; c < 14; c++) begin
            check("abort_valid", vld, 0);
            @(negedge clk);
        end

        for (int n = 0; n < 3500; n++) begin
            if (n % 97 == 0) run_op(1'b1, 8'h80, 4'hF);
            else run_op(1'($urandom), 8'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
